// File: rtl/traffic_state_seq_if.sv
// Port bundle for the traffic phase sequencer: prescaler/request inputs in,
// registered phase code and status out.
interface traffic_state_seq_if #(
  parameter int unsigned CNT_W = 8
);
  // No valid/ready pair here: tick is a one-cycle enable pulse, ped_req and
  // emerg are levels sampled every rising edge, and every output is a
  // registered level that the consumer may read in any cycle.
  logic             tick;
  logic             ped_req;
  logic             emerg;
  logic [1:0]       presState;
  logic [CNT_W-1:0] remaining;
  logic             phase_start;
  logic             ped_walk;

  modport master (
    output tick,
    output ped_req,
    output emerg,
    input  presState,
    input  remaining,
    input  phase_start,
    input  ped_walk
  );

  modport slave (
    input  tick,
    input  ped_req,
    input  emerg,
    output presState,
    output remaining,
    output phase_start,
    output ped_walk
  );
endinterface

// File: rtl/traffic_state_seq.sv
// GREEN -> YELLOW -> RED phase sequencer with tick-based dwell counting,
// pedestrian green truncation and an emergency hold-in-red override.
module traffic_state_seq #(
  parameter int unsigned GREEN_TICKS  = 8,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned RED_TICKS    = 6,
  parameter int unsigned MIN_GREEN    = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  traffic_state_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_RED    = 2'b10
  } phase_e;

  localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_TICKS);
  localparam logic [CNT_W-1:0] RED_L    = CNT_W'(RED_TICKS);
  localparam logic [CNT_W-1:0] MIN_L    = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] ONE_L    = CNT_W'(1);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pend_q, pend_d;
  logic             walk_q, walk_d;
  logic             pstart_q, pstart_d;

  logic             last_tick;
  logic             ped_any;

  // The 1 -> next-phase move replaces the decrement, so rem never hits 0.
  assign last_tick = bus.tick && (rem_q == ONE_L);
  assign ped_any   = pend_q || bus.ped_req;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    pend_d   = pend_q || bus.ped_req;
    walk_d   = walk_q;
    pstart_d = 1'b0;

    unique case (state_q)
      PH_GREEN: begin
        if (bus.emerg) begin
          state_d  = PH_YELLOW;
          rem_d    = YELLOW_L;
          pstart_d = 1'b1;
        end else if (ped_any && (rem_q > MIN_L)) begin
          rem_d = MIN_L;
        end else if (last_tick) begin
          state_d  = PH_YELLOW;
          rem_d    = YELLOW_L;
          pstart_d = 1'b1;
        end else if (bus.tick) begin
          rem_d = rem_q - ONE_L;
        end
      end

      PH_YELLOW: begin
        if (last_tick) begin
          // The request being served moves into ped_walk; a request arriving
          // on this very edge stays pending for the next cycle.
          state_d  = PH_RED;
          rem_d    = RED_L;
          walk_d   = pend_q;
          pend_d   = bus.ped_req;
          pstart_d = 1'b1;
        end else if (bus.tick) begin
          rem_d = rem_q - ONE_L;
        end
      end

      PH_RED: begin
        if (bus.emerg) begin
          rem_d = RED_L;
        end else if (last_tick) begin
          state_d  = PH_GREEN;
          rem_d    = GREEN_L;
          walk_d   = 1'b0;
          pstart_d = 1'b1;
        end else if (bus.tick) begin
          rem_d = rem_q - ONE_L;
        end
      end

      default: begin
        state_d = PH_RED;
        rem_d   = RED_L;
        walk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PH_RED;
      rem_q    <= RED_L;
      pend_q   <= 1'b0;
      walk_q   <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      pend_q   <= pend_d;
      walk_q   <= walk_d;
      pstart_q <= pstart_d;
    end
  end

  assign bus.presState   = state_q;
  assign bus.remaining   = rem_q;
  assign bus.phase_start = pstart_q;
  assign bus.ped_walk    = walk_q;

  a_no_code3: assert property (@(posedge clk) disable iff (!rst_n)
    state_q != 2'b11);

  a_rem_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    rem_q != '0);

  a_walk_only_red: assert property (@(posedge clk) disable iff (!rst_n)
    walk_q |-> (state_q == PH_RED));

endmodule

// File: doc/traffic_state_seq.md
# traffic_state_seq

Sequencer that produces the 2-bit `presState` phase code consumed by the traffic-light output decoder.
- Steps GREEN → YELLOW → RED → GREEN.
- Each phase lasts a programmed number of prescaler ticks.
- Supports pedestrian-request green truncation and an emergency hold-in-red override.
- Sits between the tick prescaler and the light output decode.

## Interface
- `GREEN_TICKS`, default 8: GREEN dwell in ticks; must be ≥1.
- `YELLOW_TICKS`, default 3: YELLOW dwell in ticks; must be ≥1.
- `RED_TICKS`, default 6: RED dwell in ticks; must be ≥1.
- `MIN_GREEN`, default 2: GREEN length after a pedestrian truncation; must satisfy 1 ≤ MIN_GREEN ≤ GREEN_TICKS.
- `CNT_W`, default 8: dwell counter width; every dwell parameter must fit in it.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle enable pulse from the prescaler; dwell counts only on cycles where it is high.
- `ped_req`  in  1  pedestrian request, level-sampled each cycle.
- `emerg`  in  1  emergency override, level, synchronous.
- `presState`  out  2  phase code: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 RED. 2'b11 is never driven.
- `remaining`  out  CNT_W  ticks left in the current phase, counting N…1.
- `phase_start`  out  1  one-cycle pulse in the first cycle of every new phase.
- `ped_walk`  out  1  high for the whole of a RED phase that serves a pedestrian request.

## Operation
- **Reset values:** `presState`=RED, `remaining`=RED_TICKS, `phase_start`=0, `ped_walk`=0; pending flag cleared.
- **Phase entry:** `remaining` loads that phase's *_TICKS value and `phase_start` is 1 for exactly one cycle. The value loaded is MIN_GREEN never; truncation happens only later, inside GREEN.
- **Countdown:** on an edge with `tick`=1:
  - if `remaining`==1, move to the next phase;
  - otherwise decrement `remaining`.
  - With `tick`=0, everything holds.
- **Pedestrian pending flag:**
  - Set on any edge with `ped_req`=1.
  - Cleared on the YELLOW→RED edge, at which `ped_walk` is set to the flag's value before clearing.
  - `ped_walk` clears on the RED→GREEN edge.
  - A request raised during RED stays pending and is served at the next YELLOW→RED edge.
- **Truncation:** in GREEN with the flag set (or `ped_req`=1 this edge) and `remaining` > MIN_GREEN, `remaining` loads MIN_GREEN. There is no decrement on that edge. If `remaining` ≤ MIN_GREEN, counting is unchanged.
- **Emergency, while `emerg`=1:**
  - GREEN → YELLOW on the next edge regardless of `tick`.
  - YELLOW counts down normally into RED.
  - RED reloads `remaining`=RED_TICKS every edge and never exits.
  - After deassertion, RED counts down its full RED_TICKS from the current value.
- **Priority on the same edge:** `emerg` > truncation > tick countdown.
- **Arithmetic:** `remaining` is unsigned and never reaches 0 or wraps. The 1→next-phase transition replaces the decrement.

## Timing
- Registered outputs, no combinational input→output paths.
- A state change is visible in the cycle after the edge that caused it.
- With `tick` every cycle, the full cycle is RED_TICKS+GREEN_TICKS+YELLOW_TICKS clocks.
- `emerg` takes effect at the first edge after assertion: GREEN→YELLOW latency is 1 clock.
- Async reset: outputs take reset values immediately on `rst_n` falling, without a clock edge. The first transition after release needs RED_TICKS ticks.
- `phase_start` is never asserted in the cycle immediately after reset.

## Test plan
All scenarios use GREEN=5, YELLOW=2, RED=4, MIN_GREEN=2.

1. **Reset and free-run:** reset, then `tick` every cycle → RED for 4 clocks, GREEN 5, YELLOW 2, repeating with period 11. `phase_start` pulses at each entry; `presState` never equals 2'b11.
2. **Sparse ticks:** `tick` every 3rd cycle → `remaining` changes only on tick edges. RED lasts 12 clocks.
3. **Truncation:** `ped_req` pulse while GREEN `remaining`=4 → `remaining`=2 next cycle. YELLOW follows after 2 ticks. The next RED has `ped_walk`=1 for all 4 ticks, then 0 in GREEN. A request at `remaining`=2 does not change the count.
4. **Emergency:** `emerg` rises in GREEN with `remaining`=5 → next cycle YELLOW, `remaining`=2, `phase_start`=1. RED is then held with `remaining`=4 for 20 clocks. Deassert → GREEN after 4 ticks.
5. **Simultaneous events:** `emerg`, `ped_req` and `tick` together in GREEN → YELLOW is entered and no truncation is applied. The pending flag is served at the following YELLOW→RED edge (`ped_walk`=1).
6. **Reset mid-phase:** drop `rst_n` mid-YELLOW with no clock edge → immediately RED, `remaining`=4, `ped_walk`=0. The pending flag is cleared, so the next RED has `ped_walk`=0.
